// File: rtl/test_frame_generator_if.sv
// AXI-Stream link carrying generated test frames from the frame generator to the port.
interface test_frame_generator_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 3
);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [DATA_WIDTH/8-1:0] user;
    logic [ID_WIDTH-1:0]     id;
    logic                    valid;
    logic                    ready;

    modport master (output data, keep, last, user, id, valid, input ready);
    modport slave  (input data, keep, last, user, id, valid, output ready);
endinterface

// File: rtl/test_frame_generator.sv
// Speed-test IPv4 frame source: header beat plus LFSR payload beats, with frame/byte counters.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h04
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module test_frame_generator #(
    parameter int          DATA_WIDTH = 512,
    parameter int          ID_WIDTH   = 3,
    parameter int unsigned PORT_ID    = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] cfg_frame_len,
    input  logic [15:0] cfg_gap,
    input  logic [15:0] cfg_seed,
    input  logic [47:0] cfg_src_mac,
    input  logic [47:0] cfg_dst_mac,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [7:0]  cfg_ttl,
    output logic [31:0] tx_frames,
    output logic [47:0] tx_bytes,
    test_frame_generator_if.master axis_m
);
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ether_type;
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] total_length;
        logic [15:0] id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } frame_header_t;

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    state_t      state, state_nx;
    logic [10:0] frame_len;
    logic [4:0]  last_idx, beat;
    logic [63:0] keep_last;
    logic [15:0] gap, gap_cnt, frame_id, pat;
    logic        stop_pend;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;
    logic [7:0]  ttl;

    logic [10:0] len_c;
    logic [15:0] seed_nz;
    logic [5:0]  len_rem;
    logic        is_last, hs;
    logic [19:0] csum_acc;
    logic [15:0] csum;
    frame_header_t hdr;
    logic [271:0] hdr_bits;
    logic [511:0] data_c;

    assign len_c   = (cfg_frame_len < 16'd60)   ? 11'd60 :
                     (cfg_frame_len > 16'd1514) ? 11'd1514 : cfg_frame_len[10:0];
    assign len_rem = len_c[5:0];
    assign seed_nz = (cfg_seed == 16'h0000) ? 16'h0001 : cfg_seed;
    assign is_last = (beat == last_idx);
    assign hs      = axis_m.valid && axis_m.ready;
    assign ready   = (state == IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = HDR;
            HDR, PAY: begin
                if (hs) begin
                    if (!is_last)               state_nx = PAY;
                    else if (stop_pend || stop) state_nx = IDLE;
                    else if (gap == 16'd0)      state_nx = HDR;
                    else                        state_nx = GAP;
                end
            end
            GAP: begin
                if (stop_pend || stop)      state_nx = IDLE;
                else if (gap_cnt == 16'd1)  state_nx = HDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Header fields all come from registers, so the checksum settles during PAY/GAP.
    always_comb begin
        csum_acc = 20'({8'h45, `TEST_FRAME_TOS}) + 20'({5'd0, frame_len} - 16'd14)
                 + 20'(frame_id) + 20'({ttl, `TEST_FRAME_PROTO})
                 + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                 + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
        csum_acc = 20'(csum_acc[15:0]) + 20'(csum_acc[19:16]);
        csum_acc = 20'(csum_acc[15:0]) + 20'(csum_acc[19:16]);
        csum     = ~csum_acc[15:0];
    end

    always_comb begin
        hdr.dst_mac      = dst_mac;
        hdr.src_mac      = src_mac;
        hdr.ether_type   = 16'h0800;
        hdr.version      = 4'd4;
        hdr.ihl          = 4'd5;
        hdr.tos          = `TEST_FRAME_TOS;
        hdr.total_length = {5'd0, frame_len} - 16'd14;
        hdr.id           = frame_id;
        hdr.flags_frag   = '0;
        hdr.ttl          = ttl;
        hdr.proto        = `TEST_FRAME_PROTO;
        hdr.checksum     = csum;
        hdr.src_ip       = src_ip;
        hdr.dst_ip       = dst_ip;
        hdr_bits         = hdr;
    end

    always_comb begin
        data_c = '0;
        for (int unsigned i = 0; i < 32; i++) data_c[16*i +: 16] = pat;
        if (state == HDR)
            for (int unsigned i = 0; i < 34; i++) data_c[8*i +: 8] = hdr_bits[271 - 8*i -: 8];
    end

    always_comb begin
        axis_m.valid = (state == HDR) || (state == PAY);
        axis_m.last  = axis_m.valid && is_last;
        axis_m.keep  = !axis_m.valid ? '0 : (is_last ? keep_last : '1);
        axis_m.data  = axis_m.valid ? data_c : '0;
        axis_m.user  = '0;
        axis_m.id    = ID_WIDTH'(PORT_ID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            frame_len <= '0; last_idx <= '0; beat <= '0; keep_last <= '0;
            gap <= '0; gap_cnt <= '0; frame_id <= '0; pat <= '0; stop_pend <= 1'b0;
            src_mac <= '0; dst_mac <= '0; src_ip <= '0; dst_ip <= '0; ttl <= '0;
            tx_frames <= '0; tx_bytes <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (start) begin
                    frame_len <= len_c;
                    last_idx  <= 5'((len_c - 11'd1) >> 6);
                    keep_last <= (len_rem == 6'd0) ? '1 : (64'd1 << len_rem) - 64'd1;
                    gap       <= cfg_gap;
                    frame_id  <= seed_nz;
                    pat       <= seed_nz;
                    beat      <= '0;
                    stop_pend <= 1'b0;
                    src_mac   <= cfg_src_mac;
                    dst_mac   <= cfg_dst_mac;
                    src_ip    <= cfg_src_ip;
                    dst_ip    <= cfg_dst_ip;
                    ttl       <= cfg_ttl;
                    tx_frames <= '0;
                    tx_bytes  <= '0;
                end
            end else begin
                if (stop) stop_pend <= 1'b1;
                if (hs) begin
                    if (is_last) begin
                        beat      <= '0;
                        frame_id  <= lfsr_step(frame_id);
                        pat       <= lfsr_step(frame_id);
                        gap_cnt   <= gap;
                        tx_frames <= tx_frames + 32'd1;
                        tx_bytes  <= tx_bytes + 48'(frame_len);
                    end else begin
                        beat <= beat + 5'd1;
                        pat  <= lfsr_step(pat);
                    end
                end
                if (state == GAP) gap_cnt <= gap_cnt - 16'd1;
                if (state_nx == IDLE) stop_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_test_frame_generator.sv
// Directed self-checking bench for test_frame_generator: header, payload, gap, stop and reset behaviour.
`ifndef TEST_FRAME_TOS
`define TEST_FRAME_TOS 8'h04
`endif
`ifndef TEST_FRAME_PROTO
`define TEST_FRAME_PROTO 8'hFD
`endif

module tb_test_frame_generator;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] cfg_frame_len, cfg_gap, cfg_seed;
    logic [47:0] cfg_src_mac, cfg_dst_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip;
    logic [7:0]  cfg_ttl;
    logic        ready;
    logic [31:0] tx_frames;
    logic [47:0] tx_bytes;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    test_frame_generator_if #(.DATA_WIDTH(512), .ID_WIDTH(3)) axis_m ();

    test_frame_generator #(.DATA_WIDTH(512), .ID_WIDTH(3), .PORT_ID(5)) dut (
        .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
        .cfg_src_mac(cfg_src_mac), .cfg_dst_mac(cfg_dst_mac),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip), .cfg_ttl(cfg_ttl),
        .tx_frames(tx_frames), .tx_bytes(tx_bytes), .axis_m(axis_m)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lf(input logic [15:0] x);
        return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
    endfunction

    function automatic logic [15:0] csum_model(input logic [15:0] tl, input logic [15:0] id,
                                               input logic [7:0] t, input logic [31:0] sip,
                                               input logic [31:0] dip);
        int unsigned s;
        s = 32'h4500 + 32'(`TEST_FRAME_TOS) + 32'(tl) + 32'(id) + 32'({t, `TEST_FRAME_PROTO})
          + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic logic [7:0] bt(input logic [511:0] d, input int i);
        return d[8*i +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_header(input string tag, input logic [15:0] id, input logic [15:0] tl);
        logic [511:0] d;
        d = axis_m.data;
        check({tag, " dmac0"},  64'(bt(d, 0)), 64'(cfg_dst_mac[47:40]));
        check({tag, " dmac5"},  64'(bt(d, 5)), 64'(cfg_dst_mac[7:0]));
        check({tag, " smac0"},  64'(bt(d, 6)), 64'(cfg_src_mac[47:40]));
        check({tag, " etype"},  64'({bt(d, 12), bt(d, 13)}), 64'h0800);
        check({tag, " vihl"},   64'(bt(d, 14)), 64'h45);
        check({tag, " tos"},    64'(bt(d, 15)), 64'(`TEST_FRAME_TOS));
        check({tag, " totlen"}, 64'({bt(d, 16), bt(d, 17)}), 64'(tl));
        check({tag, " ipid"},   64'({bt(d, 18), bt(d, 19)}), 64'(id));
        check({tag, " frag"},   64'({bt(d, 20), bt(d, 21)}), 64'h0);
        check({tag, " ttl"},    64'(bt(d, 22)), 64'(cfg_ttl));
        check({tag, " proto"},  64'(bt(d, 23)), 64'(`TEST_FRAME_PROTO));
        check({tag, " csum"},   64'({bt(d, 24), bt(d, 25)}),
              64'(csum_model(tl, id, cfg_ttl, cfg_src_ip, cfg_dst_ip)));
        check({tag, " sip"},    64'({bt(d, 26), bt(d, 27), bt(d, 28), bt(d, 29)}), 64'(cfg_src_ip));
        check({tag, " dip"},    64'({bt(d, 30), bt(d, 31), bt(d, 32), bt(d, 33)}), 64'(cfg_dst_ip));
        check({tag, " tid"},    64'(axis_m.id), 64'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0]  p, id2;
        logic [511:0] prev_data;
        logic [63:0]  prev_keep;
        logic         prev_last, prev_stall, measuring, saw_f2;
        logic [31:0]  rpat;
        int           gap_len, last_count;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_frame_len = 16'd20; cfg_gap = 16'd0; cfg_seed = 16'h1234;
        cfg_dst_mac = 48'h0211_2233_4455; cfg_src_mac = 48'h0266_7788_99AA;
        cfg_src_ip = 32'hC0A8_0001; cfg_dst_ip = 32'hC0A8_0002; cfg_ttl = 8'd64;
        axis_m.ready = 1'b1;
        step(); step();
        check("rst ready", 64'(ready), 64'd1);
        check("rst valid", 64'(axis_m.valid), 64'd0);
        check("rst last",  64'(axis_m.last), 64'd0);
        check("rst keep",  axis_m.keep, 64'd0);
        check("rst data",  64'(axis_m.data == '0), 64'd1);
        check("rst frames", 64'(tx_frames), 64'd0);
        check("rst bytes", tx_bytes, 64'd0);
        rst = 1'b0;
        step();

        // A: length 20 clamps to 60, single-beat frames, stop alongside the third last beat
        start = 1'b1;
        step();
        start = 1'b0;
        check("A ready_low", 64'(ready), 64'd0);
        check("A f1 valid", 64'(axis_m.valid), 64'd1);
        check("A f1 last",  64'(axis_m.last), 64'd1);
        check("A f1 keep",  axis_m.keep, 64'h0FFF_FFFF_FFFF_FFFF);
        check_header("A f1", 16'h1234, 16'd46);
        check("A f1 pat_even", 64'(bt(axis_m.data, 34)), 64'h34);
        check("A f1 pat_odd",  64'(bt(axis_m.data, 59)), 64'h12);
        step();
        check("A f2 valid", 64'(axis_m.valid), 64'd1);
        check("A f2 id", 64'({bt(axis_m.data, 18), bt(axis_m.data, 19)}), 64'h091A);
        check_header("A f2", 16'h091A, 16'd46);
        step();
        check("A f3 id", 64'({bt(axis_m.data, 18), bt(axis_m.data, 19)}), 64'h848D);
        check_header("A f3", 16'h848D, 16'd46);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("A end ready",  64'(ready), 64'd1);
        check("A end valid",  64'(axis_m.valid), 64'd0);
        check("A end frames", 64'(tx_frames), 64'd3);
        check("A end bytes",  tx_bytes, 64'd180);
        step();

        // B: length 2000 clamps to 1514, seed 0 becomes 1, stop requested mid-payload
        cfg_frame_len = 16'd2000; cfg_seed = 16'h0000; cfg_gap = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        p = 16'h0001;
        for (int k = 0; k < 24; k++) begin
            if (k == 0) check_header("B hdr", 16'h0001, 16'd1500);
            check($sformatf("B b%0d valid", k), 64'(axis_m.valid), 64'd1);
            check($sformatf("B b%0d pat_lo", k), 64'(bt(axis_m.data, 40)), 64'(p[7:0]));
            check($sformatf("B b%0d pat_hi", k), 64'(bt(axis_m.data, 41)), 64'(p[15:8]));
            check($sformatf("B b%0d keep", k), axis_m.keep,
                  (k == 23) ? 64'h0000_03FF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
            check($sformatf("B b%0d last", k), 64'(axis_m.last), (k == 23) ? 64'd1 : 64'd0);
            stop = (k == 10);
            step();
            p = lf(p);
        end
        stop = 1'b0;
        check("B end ready",  64'(ready), 64'd1);
        check("B end valid",  64'(axis_m.valid), 64'd0);
        check("B end frames", 64'(tx_frames), 64'd1);
        check("B end bytes",  tx_bytes, 64'd1514);
        step();
        check("B no_hdr", 64'(axis_m.valid), 64'd0);

        // C: 128-byte frames, gap 5, ready backpressure
        cfg_frame_len = 16'd128; cfg_gap = 16'd5; cfg_seed = 16'h0BAD;
        rpat = 32'b1011_0010_1101_0011_0110_1001_1100_0101;
        start = 1'b1;
        step();
        start = 1'b0;
        check("C f1 id", 64'({bt(axis_m.data, 18), bt(axis_m.data, 19)}), 64'h0BAD);
        id2 = lf(16'h0BAD);
        prev_stall = 1'b0; measuring = 1'b0; saw_f2 = 1'b0;
        gap_len = 0; last_count = 0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 400 && last_count < 2; cyc++) begin
            stop = 1'b0;
            axis_m.ready = rpat[cyc % 32];
            if (prev_stall) begin
                check("C stall data", 64'(axis_m.data == prev_data), 64'd1);
                check("C stall keep", axis_m.keep, prev_keep);
                check("C stall last", 64'(axis_m.last), 64'(prev_last));
            end
            if (measuring) begin
                if (!axis_m.valid) gap_len++;
                else begin
                    measuring = 1'b0;
                    check("C gap_len", 64'(gap_len), 64'd5);
                end
            end
            if (last_count == 1 && axis_m.valid && !saw_f2) begin
                saw_f2 = 1'b1;
                check("C f2 id", 64'({bt(axis_m.data, 18), bt(axis_m.data, 19)}), 64'(id2));
                stop = 1'b1;
            end
            prev_stall = axis_m.valid && !axis_m.ready;
            prev_data = axis_m.data; prev_keep = axis_m.keep; prev_last = axis_m.last;
            if (axis_m.valid && axis_m.ready && axis_m.last) begin
                last_count++;
                if (last_count == 1) begin
                    measuring = 1'b1;
                    gap_len = 0;
                end
            end
            step();
        end
        stop = 1'b0;
        axis_m.ready = 1'b1;
        check("C frames_seen", 64'(last_count), 64'd2);
        check("C end ready",  64'(ready), 64'd1);
        check("C end frames", 64'(tx_frames), 64'd2);
        check("C end bytes",  tx_bytes, 64'd256);
        step();

        // D: reset on beat 10, then start+stop together (start wins)
        cfg_frame_len = 16'd1514; cfg_gap = 16'd0; cfg_seed = 16'h00FF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check("D beat10 valid", 64'(axis_m.valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("D rst valid",  64'(axis_m.valid), 64'd0);
        check("D rst ready",  64'(ready), 64'd1);
        check("D rst frames", 64'(tx_frames), 64'd0);
        check("D rst bytes",  tx_bytes, 64'd0);
        cfg_frame_len = 16'd10; cfg_seed = 16'hACE1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("D f1 valid", 64'(axis_m.valid), 64'd1);
        check_header("D f1", 16'hACE1, 16'd46);
        step();
        check("D f2 valid", 64'(axis_m.valid), 64'd1);
        check("D f2 id", 64'({bt(axis_m.data, 18), bt(axis_m.data, 19)}), 64'h5670);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("D end ready",  64'(ready), 64'd1);
        check("D end frames", 64'(tx_frames), 64'd2);
        check("D end bytes",  tx_bytes, 64'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
